// File: rtl/lcd_writer_pkg.sv
// Shared types and constants for the 8080-style LCD bus writer.
// Optional statistics counter is enabled with LCD_8080_WRITER_STATS_EN.
package lcd_writer_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        WR_LOW  = 3'd2,
        WR_HIGH = 3'd3,
        HOLD    = 3'd4
    } lcd_state_e;

    localparam int DEF_DATA_WIDTH  = 16;
    localparam int DEF_FIFO_DEPTH  = 8;
    localparam int DEF_WR_LOW_CYC  = 2;
    localparam int DEF_WR_HIGH_CYC = 2;
    localparam int DEF_CS_HOLD_CYC = 1;

    localparam logic RS_CMD  = 1'b0;
    localparam logic RS_DATA = 1'b1;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/lcd_wr_fifo.sv
// Synchronous word FIFO holding {rs, data}; push and pop may coincide.
// Pointers wrap naturally; level tracks occupancy from 0 to DEPTH.
module lcd_wr_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [LW-1:0]    level_r;
    logic             push_s;
    logic             pop_s;

    assign push_s = push && !full;
    assign pop_s  = pop && !empty;
    assign full   = (level_r == LW'(DEPTH));
    assign empty  = (level_r == {LW{1'b0}});
    assign level  = level_r;
    assign rdata  = mem_r[rd_ptr_r];

    // Storage array, written on accepted pushes only.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            level_r  <= {LW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LW'(1);
                2'b01:   level_r <= level_r - LW'(1);
                default: level_r <= level_r;
            endcase
        end
    end

endmodule

// File: rtl/lcd_8080_writer.sv
// Buffered 8080 parallel-bus writer: FIFO of {rs, data} words drained as CS-low bursts.
// Define LCD_8080_WRITER_STATS_EN to add the word_cnt output (count of WR rising edges).
module lcd_8080_writer
    import lcd_writer_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
    parameter int WR_LOW_CYC  = DEF_WR_LOW_CYC,
    parameter int WR_HIGH_CYC = DEF_WR_HIGH_CYC,
    parameter int CS_HOLD_CYC = DEF_CS_HOLD_CYC
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_rs,
    input  logic [DATA_WIDTH-1:0]         in_data,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          LCD_CS,
    output logic                          LCD_WR,
    output logic                          LCD_RS,
    output logic [DATA_WIDTH-1:0]         LCD_DATA
`ifdef LCD_8080_WRITER_STATS_EN
    ,
    output logic [31:0]                   word_cnt
`endif
);
    localparam int CNT_W = $clog2(max3(WR_LOW_CYC, WR_HIGH_CYC, CS_HOLD_CYC)) + 1;

    lcd_state_e            state_r, state_s;
    logic [CNT_W-1:0]      cnt_r, cnt_s;
    logic                  cs_r, cs_s;
    logic                  wr_r, wr_s;
    logic                  rs_r, rs_s;
    logic [DATA_WIDTH-1:0] data_r, data_s;
    logic                  pop_s;
    logic [DATA_WIDTH:0]   head_s;
    logic                  full_s;
    logic                  empty_s;

    lcd_wr_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (in_valid && !full_s),
        .wdata ({in_rs, in_data}),
        .pop   (pop_s),
        .rdata (head_s),
        .full  (full_s),
        .empty (empty_s),
        .level (fifo_level)
    );

    assign in_ready = !full_s;
    assign busy     = !empty_s || (state_r != IDLE);
    assign LCD_CS   = cs_r;
    assign LCD_WR   = wr_r;
    assign LCD_RS   = rs_r;
    assign LCD_DATA = data_r;

    // Next-state and next-output decode; RS/DATA only reload when entering SETUP.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        cs_s    = cs_r;
        wr_s    = wr_r;
        rs_s    = rs_r;
        data_s  = data_r;
        pop_s   = 1'b0;
        case (state_r)
            IDLE: begin
                wr_s = 1'b1;
                if (!empty_s) begin
                    pop_s   = 1'b1;
                    rs_s    = head_s[DATA_WIDTH];
                    data_s  = head_s[DATA_WIDTH-1:0];
                    cs_s    = 1'b0;
                    state_s = SETUP;
                end else begin
                    cs_s = 1'b1;
                end
            end
            SETUP: begin
                wr_s    = 1'b0;
                cnt_s   = {CNT_W{1'b0}};
                state_s = WR_LOW;
            end
            WR_LOW: begin
                if (cnt_r == CNT_W'(WR_LOW_CYC - 1)) begin
                    wr_s    = 1'b1;
                    cnt_s   = {CNT_W{1'b0}};
                    state_s = WR_HIGH;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            WR_HIGH: begin
                if (cnt_r == CNT_W'(WR_HIGH_CYC - 1)) begin
                    cnt_s = {CNT_W{1'b0}};
                    if (!empty_s) begin
                        pop_s   = 1'b1;
                        rs_s    = head_s[DATA_WIDTH];
                        data_s  = head_s[DATA_WIDTH-1:0];
                        state_s = SETUP;
                    end else begin
                        state_s = HOLD;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            HOLD: begin
                if (cnt_r == CNT_W'(CS_HOLD_CYC - 1)) begin
                    cs_s    = 1'b1;
                    cnt_s   = {CNT_W{1'b0}};
                    state_s = IDLE;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = {CNT_W{1'b0}};
                cs_s    = 1'b1;
                wr_s    = 1'b1;
            end
        endcase
    end

    // State, timing counter and bus output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            cs_r    <= 1'b1;
            wr_r    <= 1'b1;
            rs_r    <= RS_DATA;
            data_r  <= {DATA_WIDTH{1'b0}};
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            cs_r    <= cs_s;
            wr_r    <= wr_s;
            rs_r    <= rs_s;
            data_r  <= data_s;
        end
    end

`ifdef LCD_8080_WRITER_STATS_EN
    logic [31:0] word_cnt_r;

    assign word_cnt = word_cnt_r;

    // Counts WR rising edges; wraps naturally at 32 bits.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            word_cnt_r <= 32'd0;
        end else if ((state_r == WR_LOW) && (state_s == WR_HIGH)) begin
            word_cnt_r <= word_cnt_r + 32'd1;
        end else begin
            word_cnt_r <= word_cnt_r;
        end
    end
`endif

endmodule

// File: tb/tb_lcd_8080_writer.sv
// Self-checking bench for lcd_8080_writer: directed timing checks plus random word
// streams compared against an in-order word queue and closed-form timing figures.
module tb_lcd_8080_writer;
    import lcd_writer_pkg::*;

    localparam int DW = 16;
    localparam int FD = 8;
    localparam int WL = 2;
    localparam int WH = 2;
    localparam int CH = 1;
    localparam int LW = $clog2(FD) + 1;
    localparam int WORD_PER  = 1 + WL + WH;
    localparam int SINGLE_CS = WORD_PER + CH;

    logic          clk;
    logic          rstn;
    logic          in_valid;
    logic          in_ready;
    logic          in_rs;
    logic [DW-1:0] in_data;
    logic          busy;
    logic [LW-1:0] fifo_level;
    logic          LCD_CS;
    logic          LCD_WR;
    logic          LCD_RS;
    logic [DW-1:0] LCD_DATA;
`ifdef LCD_8080_WRITER_STATS_EN
    logic [31:0]   word_cnt;
`endif

    lcd_8080_writer #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (FD),
        .WR_LOW_CYC (WL),
        .WR_HIGH_CYC(WH),
        .CS_HOLD_CYC(CH)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_rs      (in_rs),
        .in_data    (in_data),
        .busy       (busy),
        .fifo_level (fifo_level),
        .LCD_CS     (LCD_CS),
        .LCD_WR     (LCD_WR),
        .LCD_RS     (LCD_RS),
        .LCD_DATA   (LCD_DATA)
`ifdef LCD_8080_WRITER_STATS_EN
        ,
        .word_cnt   (word_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Bus monitor state, updated on every falling clock edge.
    int            cyc = 0;
    logic          prev_wr = 1'b1;
    logic          prev_cs = 1'b1;
    logic [DW:0]   at_fall = '0;
    logic [DW:0]   obs_q[$];
    int            fall_q[$];
    int            cs_fall_q[$];
    int            cs_rises = 0;
    int            cs_low_cnt = 0;
    int            wr_low_cnt = 0;
    int            hold_viol = 0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rstn) begin
            if (!LCD_CS) cs_low_cnt <= cs_low_cnt + 1;
            if (!LCD_WR) wr_low_cnt <= wr_low_cnt + 1;
            if (prev_wr && !LCD_WR) begin
                fall_q.push_back(cyc + 1);
                at_fall <= {LCD_RS, LCD_DATA};
            end
            if (!prev_wr && LCD_WR) begin
                obs_q.push_back({LCD_RS, LCD_DATA});
                if ({LCD_RS, LCD_DATA} !== at_fall) hold_viol <= hold_viol + 1;
            end
            if (prev_cs && !LCD_CS) cs_fall_q.push_back(cyc + 1);
            if (!prev_cs && LCD_CS) cs_rises <= cs_rises + 1;
        end
        prev_wr <= LCD_WR;
        prev_cs <= LCD_CS;
    end

    // Reference model: words accepted, in order.
    logic [DW:0] exp_q[$];
    logic [DW:0] words[$];
    int          saw_full;
    int          lvl_over;
    int          b_cs, b_wr, b_rise, b_hold, c0, n0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [DW:0] w[$], input int bound);
        int i;
        int n;
        i = 0;
        n = 0;
        while (i < w.size() && n < bound) begin
            in_valid = 1'b1;
            {in_rs, in_data} = w[i];
            if (int'(fifo_level) > FD) lvl_over++;
            if (!in_ready && int'(fifo_level) == FD) saw_full = 1;
            if (in_ready) begin
                exp_q.push_back(w[i]);
                i++;
            end
            tick();
            n++;
        end
        in_valid = 1'b0;
        check("send_timeout", 64'(i == w.size()), 64'd1);
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while ((busy || !LCD_CS) && n < bound) begin
            if (int'(fifo_level) > FD) lvl_over++;
            tick();
            n++;
        end
        check("drain_timeout", 64'(n < bound), 64'd1);
    endtask

    task automatic compare_words(input string tag);
        check({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            check({tag, "_word"}, 64'(obs_q[i]), 64'(exp_q[i]));
        end
        obs_q.delete();
        exp_q.delete();
        fall_q.delete();
        cs_fall_q.delete();
    endtask

    task automatic snap();
        b_cs   = cs_low_cnt;
        b_wr   = wr_low_cnt;
        b_rise = cs_rises;
        b_hold = hold_viol;
    endtask

    initial begin
        rstn = 1'b0;
        in_valid = 1'b0;
        in_rs = 1'b0;
        in_data = '0;
        saw_full = 0;
        lvl_over = 0;
        tick();
        tick();
        check("rst_cs", 64'(LCD_CS), 64'd1);
        check("rst_wr", 64'(LCD_WR), 64'd1);
        check("rst_rs", 64'(LCD_RS), 64'd1);
        check("rst_data", 64'(LCD_DATA), 64'd0);
        check("rst_ready", 64'(in_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_level", 64'(fifo_level), 64'd0);
        rstn = 1'b1;
        tick();

        // Single command word: latency and strobe widths.
        snap();
        c0 = cyc;
        words = '{{RS_CMD, 16'h002A}};
        send(words, 10);
        wait_idle(50);
        check("single_cs_latency", 64'(cs_fall_q[0] - c0), 64'(1 + 1));
        check("single_wr_latency", 64'(fall_q[0] - c0), 64'(2 + 1));
        check("single_cs_low", 64'(cs_low_cnt - b_cs), 64'(SINGLE_CS));
        check("single_wr_low", 64'(wr_low_cnt - b_wr), 64'(WL));
        check("single_cs_rises", 64'(cs_rises - b_rise), 64'd1);
        compare_words("single");

        // Directed burst: one command then four pixels.
        snap();
        words = '{{RS_CMD, 16'h002C}, {RS_DATA, 16'hFFE0}, {RS_DATA, 16'hFFE0},
                  {RS_DATA, 16'hFFE0}, {RS_DATA, 16'hFFE0}};
        send(words, 20);
        wait_idle(100);
        check("burst_cs_rises", 64'(cs_rises - b_rise), 64'd1);
        check("burst_cs_low", 64'(cs_low_cnt - b_cs), 64'(5 * WORD_PER + CH));
        check("burst_wr_low", 64'(wr_low_cnt - b_wr), 64'(5 * WL));
        for (int i = 1; i < fall_q.size(); i++) begin
            check("burst_period", 64'(fall_q[i] - fall_q[i-1]), 64'(WORD_PER));
        end
        compare_words("burst");

        // Random burst.
        snap();
        words.delete();
        for (int i = 0; i < 6; i++) words.push_back((DW+1)'($urandom));
        send(words, 20);
        wait_idle(100);
        check("rburst_cs_rises", 64'(cs_rises - b_rise), 64'd1);
        check("rburst_cs_low", 64'(cs_low_cnt - b_cs), 64'(6 * WORD_PER + CH));
        compare_words("rburst");

        // Backpressure: twelve random words with the bus far slower than the producer.
        snap();
        words.delete();
        for (int i = 0; i < 12; i++) words.push_back((DW+1)'($urandom));
        send(words, 300);
        wait_idle(300);
        check("bp_saw_full", 64'(saw_full), 64'd1);
        check("bp_level_bound", 64'(lvl_over), 64'd0);
        check("bp_hold_viol", 64'(hold_viol - b_hold), 64'd0);
        compare_words("bp");

        // Reset during WR low of the third word of five.
        words.delete();
        for (int i = 0; i < 5; i++) words.push_back((DW+1)'($urandom));
        send(words, 20);
        n0 = 0;
        while (fall_q.size() < 3 && n0 < 100) begin
            tick();
            n0++;
        end
        check("mid_reach_third", 64'(fall_q.size()), 64'd3);
        check("mid_wr_low", 64'(LCD_WR), 64'd0);
        rstn = 1'b0;
        #1;
        check("mid_cs", 64'(LCD_CS), 64'd1);
        check("mid_wr", 64'(LCD_WR), 64'd1);
        check("mid_rs", 64'(LCD_RS), 64'd1);
        check("mid_data", 64'(LCD_DATA), 64'd0);
        check("mid_busy", 64'(busy), 64'd0);
        check("mid_level", 64'(fifo_level), 64'd0);
        check("mid_ready", 64'(in_ready), 64'd1);
        tick();
        rstn = 1'b1;
        n0 = fall_q.size();
        for (int i = 0; i < 40; i++) tick();
        check("mid_no_more_wr", 64'(fall_q.size()), 64'(n0));
        check("mid_idle_cs", 64'(LCD_CS), 64'd1);
        obs_q.delete();
        exp_q.delete();
        fall_q.delete();
        cs_fall_q.delete();

`ifdef LCD_8080_WRITER_STATS_EN
        check("stats_after_reset", 64'(word_cnt), 64'd0);
        words.delete();
        for (int i = 0; i < 5; i++) words.push_back((DW+1)'($urandom));
        send(words, 20);
        wait_idle(100);
        check("stats_five", 64'(word_cnt), 64'd5);
        compare_words("stats");
        force dut.word_cnt_r = 32'hFFFF_FFFF;
        tick();
        release dut.word_cnt_r;
        tick();
        check("stats_preload", 64'(word_cnt), 64'hFFFF_FFFF);
        words = '{{RS_DATA, 16'h1234}};
        send(words, 10);
        wait_idle(50);
        check("stats_wrap", 64'(word_cnt), 64'd0);
        compare_words("stats_wrap");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
